// File: rtl/cipher_dma_writer_if.sv
// Avalon-MM write-master bus used by the cipher DMA writer.
//
// Signals:
//   master_address      byte address of the current write
//   master_writedata    write data word
//   master_write        write request
//   master_waitrequest  slave stall; a write completes when it is low
//
// Modports:
//   master  driven by the DMA writer
//   slave   driven by the memory or interconnect side
interface cipher_dma_writer_if #(
  parameter int MASTER_ADDRESSWIDTH = 26,
  parameter int DATAWIDTH           = 32
);
  logic [MASTER_ADDRESSWIDTH-1:0] master_address;
  logic [DATAWIDTH-1:0]           master_writedata;
  logic                           master_write;
  logic                           master_waitrequest;

  modport master (
    output master_address,
    output master_writedata,
    output master_write,
    input  master_waitrequest
  );

  modport slave (
    input  master_address,
    input  master_writedata,
    input  master_write,
    output master_waitrequest
  );
endinterface

// File: rtl/cipher_dma_writer.sv
// Cipher DMA writer: buffers 64-bit cipher blocks in a small FIFO and writes
// each block to memory as two 32-bit Avalon writes (high word first).
//
// Ports:
//   clk, reset_n            clock, synchronous active-low reset
//   start                   one-cycle job start pulse (accepted in IDLE/DONE)
//   base_addr, block_count  job parameters, sampled on accepted start
//   in_valid, in_data       cipher block stream, no backpressure
//   avm                     Avalon write master (cipher_dma_writer_if.master)
//   busy, done              job in progress / job complete (level)
//   overflow                sticky: a block was dropped on a full FIFO
//   blocks_written          blocks fully written in the current job
module cipher_dma_writer #(
  parameter int MASTER_ADDRESSWIDTH = 26,
  parameter int DATAWIDTH           = 32,
  parameter int FIFO_DEPTH          = 8,
  parameter int COUNTWIDTH          = 14
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           start,
  input  logic [MASTER_ADDRESSWIDTH-1:0] base_addr,
  input  logic [COUNTWIDTH-1:0]          block_count,
  input  logic                           in_valid,
  input  logic [63:0]                    in_data,
  cipher_dma_writer_if.master            avm,
  output logic                           busy,
  output logic                           done,
  output logic                           overflow,
  output logic [COUNTWIDTH-1:0]          blocks_written
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [2:0] {IDLE, WAIT_DATA, WRITE_HI, WRITE_LO, DONE} state_e;

  state_e                         state_q, state_d;
  logic [63:0]                    fifo_mem_q [FIFO_DEPTH];
  logic [63:0]                    fifo_mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0]               wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]               fifo_cnt_q, fifo_cnt_d;
  logic [MASTER_ADDRESSWIDTH-1:0] cur_addr_q, cur_addr_d;
  logic [COUNTWIDTH-1:0]          job_count_q, job_count_d;
  logic [COUNTWIDTH-1:0]          blocks_written_q, blocks_written_d;
  logic [MASTER_ADDRESSWIDTH-1:0] master_address_q, master_address_d;
  logic [DATAWIDTH-1:0]           master_writedata_q, master_writedata_d;
  logic                           master_write_q, master_write_d;
  logic                           busy_q, busy_d;
  logic                           done_q, done_d;
  logic                           overflow_q, overflow_d;

  logic                           fifo_full, write_ok, push, pop, accept_start;
  logic [63:0]                    head, next_head;
  logic [COUNTWIDTH-1:0]          bw_inc;
  logic [MASTER_ADDRESSWIDTH-1:0] addr_next;

  // Handshake decode and FIFO head selection. After a pop the next head is
  // the following FIFO entry, or the block arriving this very cycle when the
  // FIFO held only the block being retired, so back-to-back blocks never
  // need a WAIT_DATA bubble.
  always_comb begin
    fifo_full    = (fifo_cnt_q == CNT_W'(FIFO_DEPTH));
    write_ok     = master_write_q && !avm.master_waitrequest;
    pop          = (state_q == WRITE_LO) && write_ok;
    accept_start = start && ((state_q == IDLE) || (state_q == DONE));
    push         = in_valid && busy_q && (!fifo_full || pop);
    head         = fifo_mem_q[rd_ptr_q];
    next_head    = (fifo_cnt_q > CNT_W'(1)) ? fifo_mem_q[rd_ptr_q + PTR_W'(1)] : in_data;
    bw_inc       = blocks_written_q + COUNTWIDTH'(1);
    addr_next    = cur_addr_q + MASTER_ADDRESSWIDTH'(8);
  end

  // Next-state logic for the FIFO, the job FSM and every registered output.
  // Bus outputs default to holding, which keeps them stable under waitrequest.
  always_comb begin
    state_d            = state_q;
    fifo_mem_d         = fifo_mem_q;
    wr_ptr_d           = wr_ptr_q;
    rd_ptr_d           = rd_ptr_q;
    fifo_cnt_d         = fifo_cnt_q;
    cur_addr_d         = cur_addr_q;
    job_count_d        = job_count_q;
    blocks_written_d   = blocks_written_q;
    master_address_d   = master_address_q;
    master_writedata_d = master_writedata_q;
    master_write_d     = master_write_q;
    busy_d             = busy_q;
    done_d             = done_q;
    overflow_d         = overflow_q;

    if (push) begin
      fifo_mem_d[wr_ptr_q] = in_data;
      wr_ptr_d             = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({push, pop})
      2'b10:   fifo_cnt_d = fifo_cnt_q + CNT_W'(1);
      2'b01:   fifo_cnt_d = fifo_cnt_q - CNT_W'(1);
      default: fifo_cnt_d = fifo_cnt_q;
    endcase
    if (in_valid && busy_q && !push) begin
      overflow_d = 1'b1;
    end

    case (state_q)
      IDLE, DONE: begin
        if (accept_start) begin
          cur_addr_d       = base_addr;
          job_count_d      = block_count;
          wr_ptr_d         = '0;
          rd_ptr_d         = '0;
          fifo_cnt_d       = '0;
          overflow_d       = 1'b0;
          blocks_written_d = '0;
          if (block_count == '0) begin
            state_d = DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            state_d = WAIT_DATA;
            busy_d  = 1'b1;
            done_d  = 1'b0;
          end
        end
      end
      WAIT_DATA: begin
        if (fifo_cnt_q != '0) begin
          state_d            = WRITE_HI;
          master_write_d     = 1'b1;
          master_address_d   = cur_addr_q;
          master_writedata_d = DATAWIDTH'(head[63:32]);
        end
      end
      WRITE_HI: begin
        if (write_ok) begin
          state_d            = WRITE_LO;
          master_address_d   = cur_addr_q + MASTER_ADDRESSWIDTH'(4);
          master_writedata_d = DATAWIDTH'(head[31:0]);
        end
      end
      WRITE_LO: begin
        if (write_ok) begin
          cur_addr_d       = addr_next;
          blocks_written_d = bw_inc;
          if (bw_inc == job_count_q) begin
            state_d        = DONE;
            master_write_d = 1'b0;
            busy_d         = 1'b0;
            done_d         = 1'b1;
          end else if ((fifo_cnt_q > CNT_W'(1)) || push) begin
            state_d            = WRITE_HI;
            master_address_d   = addr_next;
            master_writedata_d = DATAWIDTH'(next_head[63:32]);
          end else begin
            state_d        = WAIT_DATA;
            master_write_d = 1'b0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and control registers; reset abandons any job and drops the bus.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q            <= IDLE;
      wr_ptr_q           <= '0;
      rd_ptr_q           <= '0;
      fifo_cnt_q         <= '0;
      cur_addr_q         <= '0;
      job_count_q        <= '0;
      blocks_written_q   <= '0;
      master_address_q   <= '0;
      master_writedata_q <= '0;
      master_write_q     <= 1'b0;
      busy_q             <= 1'b0;
      done_q             <= 1'b0;
      overflow_q         <= 1'b0;
    end else begin
      state_q            <= state_d;
      wr_ptr_q           <= wr_ptr_d;
      rd_ptr_q           <= rd_ptr_d;
      fifo_cnt_q         <= fifo_cnt_d;
      cur_addr_q         <= cur_addr_d;
      job_count_q        <= job_count_d;
      blocks_written_q   <= blocks_written_d;
      master_address_q   <= master_address_d;
      master_writedata_q <= master_writedata_d;
      master_write_q     <= master_write_d;
      busy_q             <= busy_d;
      done_q             <= done_d;
      overflow_q         <= overflow_d;
    end
  end

  // FIFO storage needs no reset: the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    fifo_mem_q <= fifo_mem_d;
  end

  assign avm.master_address   = master_address_q;
  assign avm.master_writedata = master_writedata_q;
  assign avm.master_write     = master_write_q;
  assign busy                 = busy_q;
  assign done                 = done_q;
  assign overflow             = overflow_q;
  assign blocks_written       = blocks_written_q;

endmodule

// File: tb/tb_cipher_dma_writer.sv
// Testbench for cipher_dma_writer: directed jobs with a write scoreboard.
// Stimulus pushes every expected Avalon write into a queue; an independent
// monitor pops and compares on each completed bus write.
module tb_cipher_dma_writer;

  typedef struct packed {
    logic [25:0] addr;
    logic [31:0] data;
  } wr_t;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic [25:0] base_addr;
  logic [13:0] block_count;
  logic        in_valid;
  logic [63:0] in_data;
  logic        busy;
  logic        done;
  logic        overflow;
  logic [13:0] blocks_written;

  int  tests;
  int  failed;
  wr_t expQ[$];

  cipher_dma_writer_if #(.MASTER_ADDRESSWIDTH(26), .DATAWIDTH(32)) bus ();

  cipher_dma_writer #(
    .MASTER_ADDRESSWIDTH(26),
    .DATAWIDTH(32),
    .FIFO_DEPTH(8),
    .COUNTWIDTH(14)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .start(start),
    .base_addr(base_addr),
    .block_count(block_count),
    .in_valid(in_valid),
    .in_data(in_data),
    .avm(bus),
    .busy(busy),
    .done(done),
    .overflow(overflow),
    .blocks_written(blocks_written)
  );

  // 100 MHz clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    tests++;
    if (actual !== expected) begin
      failed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [25:0] base, input logic [13:0] count);
    start       = 1'b1;
    base_addr   = base;
    block_count = count;
    tick();
    start = 1'b0;
  endtask

  task automatic expectBlock(input logic [25:0] addr, input logic [63:0] blk);
    logic [25:0] a4;
    a4 = addr + 26'd4;
    expQ.push_back('{addr: addr, data: blk[63:32]});
    expQ.push_back('{addr: a4,   data: blk[31:0]});
  endtask

  task automatic sendBlock(input logic [25:0] addr, input logic [63:0] blk);
    in_valid = 1'b1;
    in_data  = blk;
    expectBlock(addr, blk);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic waitDone(input int budget);
    int n;
    n = 0;
    while (done !== 1'b1 && n < budget) begin
      tick();
      n++;
    end
    checkOutput("done_within_budget", {63'd0, done}, 64'd1);
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_master_write"},   {63'd0, bus.master_write}, 64'd0);
    checkOutput({tag, "_master_address"}, {38'd0, bus.master_address}, 64'd0);
    checkOutput({tag, "_master_wdata"},   {32'd0, bus.master_writedata}, 64'd0);
    checkOutput({tag, "_busy"},           {63'd0, busy}, 64'd0);
    checkOutput({tag, "_done"},           {63'd0, done}, 64'd0);
    checkOutput({tag, "_overflow"},       {63'd0, overflow}, 64'd0);
    checkOutput({tag, "_blocks_written"}, {50'd0, blocks_written}, 64'd0);
  endtask

  // Scoreboard monitor: a write completes at the coming rising edge when
  // write is high and waitrequest is low at the falling edge before it.
  always @(negedge clk) begin
    if (bus.master_write === 1'b1 && bus.master_waitrequest === 1'b0) begin
      if (expQ.size() == 0) begin
        tests++;
        failed++;
        $display("[TB] FAIL unexpected_write: got addr %0h data %0h, expected no write",
                 bus.master_address, bus.master_writedata);
      end else begin
        wr_t e;
        e = expQ.pop_front();
        checkOutput("write_addr", {38'd0, bus.master_address}, {38'd0, e.addr});
        checkOutput("write_data", {32'd0, bus.master_writedata}, {32'd0, e.data});
      end
    end
  end

  // Safety net against a hung run.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    tests                  = 0;
    failed                 = 0;
    reset_n                = 1'b0;
    start                  = 1'b0;
    base_addr              = '0;
    block_count            = '0;
    in_valid               = 1'b0;
    in_data                = '0;
    bus.master_waitrequest = 1'b0;

    repeat (3) tick();
    checkResetValues("reset");
    reset_n = 1'b1;
    tick();

    // in_valid while idle is ignored.
    in_valid = 1'b1;
    in_data  = 64'h0BAD_0BAD_0BAD_0BAD;
    repeat (3) tick();
    in_valid = 1'b0;
    tick();
    tick();
    checkOutput("idle_in_valid_overflow", {63'd0, overflow}, 64'd0);
    checkOutput("idle_in_valid_write", {63'd0, bus.master_write}, 64'd0);
    checkOutput("idle_in_valid_busy", {63'd0, busy}, 64'd0);

    // Zero-length job completes one cycle after start.
    applyStimulus(26'h40, 14'd0);
    checkOutput("count0_done", {63'd0, done}, 64'd1);
    checkOutput("count0_busy", {63'd0, busy}, 64'd0);
    tick();
    checkOutput("count0_blocks", {50'd0, blocks_written}, 64'd0);

    // Basic two-block job, including first-write latency.
    applyStimulus(26'h100, 14'd2);
    checkOutput("basic_busy", {63'd0, busy}, 64'd1);
    checkOutput("basic_done_dropped", {63'd0, done}, 64'd0);
    in_valid = 1'b1;
    in_data  = 64'h11112222_33334444;
    expectBlock(26'h100, 64'h11112222_33334444);
    tick();
    checkOutput("basic_write_not_yet", {63'd0, bus.master_write}, 64'd0);
    in_data = 64'hAAAABBBB_CCCCDDDD;
    expectBlock(26'h108, 64'hAAAABBBB_CCCCDDDD);
    tick();
    in_valid = 1'b0;
    checkOutput("basic_write_rise", {63'd0, bus.master_write}, 64'd1);
    waitDone(40);
    checkOutput("basic_busy_end", {63'd0, busy}, 64'd0);
    checkOutput("basic_blocks", {50'd0, blocks_written}, 64'd2);
    checkOutput("basic_queue_empty", 64'(expQ.size()), 64'd0);

    // Stall during the first WRITE_HI: bus held for 4 cycles.
    applyStimulus(26'h200, 14'd1);
    sendBlock(26'h200, 64'h01234567_89ABCDEF);
    tick();
    bus.master_waitrequest = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) bus.master_waitrequest = 1'b0;
      checkOutput("stall_write", {63'd0, bus.master_write}, 64'd1);
      checkOutput("stall_addr", {38'd0, bus.master_address}, 64'h200);
      checkOutput("stall_data", {32'd0, bus.master_writedata}, 64'h01234567);
      tick();
    end
    waitDone(40);
    checkOutput("stall_blocks", {50'd0, blocks_written}, 64'd1);

    // Address wrap at the top of the address space.
    applyStimulus(26'h3FFFFF8, 14'd2);
    sendBlock(26'h3FFFFF8, 64'h55556666_77778888);
    sendBlock(26'h0000000, 64'h9999AAAA_BBBBCCCC);
    waitDone(40);
    checkOutput("wrap_blocks", {50'd0, blocks_written}, 64'd2);

    // start pulsed in WRITE_LO is ignored.
    applyStimulus(26'h500, 14'd2);
    sendBlock(26'h500, 64'hFEDCBA98_76543210);
    tick();
    tick();
    checkOutput("ignore_in_write_lo", {38'd0, bus.master_address}, 64'h504);
    applyStimulus(26'h9000, 14'd5);
    sendBlock(26'h508, 64'h13579BDF_02468ACE);
    waitDone(40);
    checkOutput("ignore_blocks", {50'd0, blocks_written}, 64'd2);

    // Overflow: FIFO fills under a stall, 9th and 10th blocks dropped.
    applyStimulus(26'h1000, 14'd16);
    bus.master_waitrequest = 1'b1;
    for (int k = 0; k < 10; k++) begin
      logic [63:0] blk;
      blk      = {32'hA0A00000 + 32'(k), 32'h50500000 + 32'(k)};
      in_valid = 1'b1;
      in_data  = blk;
      if (k < 8) expectBlock(26'h1000 + 26'(8 * k), blk);
      tick();
      if (k == 7) checkOutput("ovf_before_full", {63'd0, overflow}, 64'd0);
      if (k == 8) checkOutput("ovf_on_ninth", {63'd0, overflow}, 64'd1);
    end
    in_valid               = 1'b0;
    bus.master_waitrequest = 1'b0;
    begin
      int n;
      n = 0;
      while (blocks_written !== 14'd8 && n < 100) begin
        tick();
        n++;
      end
    end
    checkOutput("ovf_first_eight", {50'd0, blocks_written}, 64'd8);
    for (int k = 8; k < 16; k++) begin
      logic [63:0] blk;
      blk      = {32'hC0C00000 + 32'(k), 32'h30300000 + 32'(k)};
      in_valid = 1'b1;
      in_data  = blk;
      expectBlock(26'h1000 + 26'(8 * k), blk);
      tick();
    end
    in_valid = 1'b0;
    waitDone(200);
    checkOutput("ovf_sticky", {63'd0, overflow}, 64'd1);
    checkOutput("ovf_blocks", {50'd0, blocks_written}, 64'd16);

    // Reset asserted during WRITE_LO abandons the job.
    applyStimulus(26'h700, 14'd1);
    sendBlock(26'h700, 64'hDEADBEEF_CAFEF00D);
    tick();
    tick();
    bus.master_waitrequest = 1'b1;
    reset_n                = 1'b0;
    checkOutput("rst_mid_in_write_lo", {38'd0, bus.master_address}, 64'h704);
    tick();
    checkResetValues("rst_mid");
    checkOutput("rst_mid_pending", 64'(expQ.size()), 64'd1);
    expQ.delete();
    reset_n                = 1'b1;
    bus.master_waitrequest = 1'b0;
    repeat (3) tick();
    checkOutput("rst_mid_no_resume", {63'd0, bus.master_write}, 64'd0);

    checkOutput("final_queue_empty", 64'(expQ.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/cipher_dma_writer.md
CIPHER_DMA_WRITER -- requirements
Module: cipher_dma_writer

Interface
REQ-001 SHALL have parameter MASTER_ADDRESSWIDTH, default 26, Avalon master byte-address width.
REQ-002 SHALL have parameter DATAWIDTH, default 32, Avalon data width.
REQ-003 SHALL have parameter FIFO_DEPTH, default 8 (power of 2), number of 64-bit entries buffered.
REQ-004 SHALL have parameter COUNTWIDTH, default 14, width of the block counters.
REQ-005 clk  input  1  clock; all logic on rising edge.
REQ-006 reset_n  input  1  reset, synchronous, active-low.
REQ-007 start  input  1  one-cycle pulse that begins a transfer job.
REQ-008 base_addr  input  MASTER_ADDRESSWIDTH  byte address of the first output word, sampled on accepted start.
REQ-009 block_count  input  COUNTWIDTH  number of 64-bit blocks in the job, sampled on accepted start.
REQ-010 in_valid  input  1  cipher core data_valid_out; one 64-bit block per asserted cycle, no backpressure.
REQ-011 in_data  input  64  cipher core encrypted_data.
REQ-012 master_address  output  MASTER_ADDRESSWIDTH  Avalon write address.
REQ-013 master_writedata  output  DATAWIDTH  Avalon write data.
REQ-014 master_write  output  1  Avalon write request.
REQ-015 master_waitrequest  input  1  Avalon stall.
REQ-016 busy  output  1  job in progress.
REQ-017 done  output  1  job complete, level.
REQ-018 overflow  output  1  sticky: a block was dropped because the FIFO was full.
REQ-019 blocks_written  output  COUNTWIDTH  blocks fully written in the current job.

Function
REQ-020 All outputs SHALL be registered.
REQ-021 The FSM SHALL have the states IDLE, WAIT_DATA, WRITE_HI, WRITE_LO and DONE.
REQ-022 start SHALL be accepted only in IDLE or DONE; it is ignored in every other state.
REQ-023 On an accepted start, the block SHALL latch the base address and block count, clear the FIFO, overflow and blocks_written, drop done, and go to WAIT_DATA (busy=1 on the next cycle).
REQ-024 An accepted start with block_count=0 SHALL go directly to DONE (busy stays 0, done=1 on the next cycle).
REQ-025 A block SHALL be pushed into the FIFO when in_valid=1 and busy=1, provided the FIFO is not full or a pop occurs in the same cycle.
REQ-026 in_valid while busy=0 SHALL be ignored and SHALL NOT set overflow.
REQ-027 in_valid while busy=1 with the FIFO full and no pop in that cycle SHALL drop the block and set overflow, which holds until the next accepted start.
REQ-028 WAIT_DATA SHALL go to WRITE_HI when the FIFO is non-empty; master_write SHALL rise exactly 2 cycles after the first block is accepted.
REQ-029 WRITE_HI SHALL drive master_write=1, master_writedata=head[63:32] and master_address=cur_addr.
REQ-030 WRITE_LO SHALL drive master_write=1, master_writedata=head[31:0] and master_address=cur_addr+4.
REQ-031 A write SHALL complete in a cycle where master_write=1 and master_waitrequest=0.
REQ-032 While master_waitrequest=1, master_address, master_writedata and master_write SHALL be held stable.
REQ-033 Completion in WRITE_HI SHALL advance the FSM to WRITE_LO on the next cycle with no idle cycle.
REQ-034 Completion in WRITE_LO SHALL pop the FIFO, add 8 to cur_addr (modulo 2^MASTER_ADDRESSWIDTH, wrap allowed), increment blocks_written, and take the next state as follows:
- DONE if blocks_written reaches the latched count;
- otherwise WRITE_HI if the FIFO still holds a block after the pop;
- otherwise WAIT_DATA.
REQ-035 master_write SHALL be 0 in IDLE, WAIT_DATA and DONE.
REQ-036 The no-stall throughput SHALL be one block per 2 cycles.
REQ-037 DONE SHALL drive done=1 and busy=0.
REQ-038 Blocks arriving after the count is reached SHALL be ignored (busy=0).

Reset
REQ-039 While reset_n=0 at a rising edge, the block SHALL enter IDLE and clear the FIFO pointers and all counters.
REQ-040 Reset values SHALL be master_write=0, master_address=0, master_writedata=0, busy=0, done=0, overflow=0, blocks_written=0.
REQ-041 Reset asserted mid-write SHALL deassert master_write on the next cycle and abandon the job; no partial state survives.

Verification
REQ-042 Basic job: start, base=0x100, count=2; blocks 0x11112222_33334444 and 0xAAAABBBB_CCCCDDDD; no stall -> writes (0x100,0x11112222), (0x104,0x33334444), (0x108,0xAAAABBBB), (0x10C,0xCCCCDDDD), then done=1, blocks_written=2.
REQ-043 Stall: waitrequest high 3 cycles during the first WRITE_HI -> address/data held for 4 cycles, then the sequence continues unchanged.
REQ-044 Overflow: count=16, waitrequest held high, 10 consecutive in_valid -> 8 blocks stored, overflow=1 on the 9th; release stall -> first 8 blocks written in order, overflow stays 1.
REQ-045 Edge cases: count=0 -> done=1 one cycle after start, no writes; base=0x3FFFFF8 with count=2 -> second block written at 0x0000000/0x0000004.
REQ-046 Control robustness: start pulsed in WRITE_LO -> ignored; in_valid in IDLE -> no write, overflow=0; reset_n low during WRITE_LO -> master_write=0 next cycle, all outputs at reset values.
